// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the CPU in reset, optionally NOP-fills imem, streams a program
// in over valid/ready, holds reset HOLD_CYCLES more cycles, then releases. Macro: BOOT_CLEAR_EN.
module imem_boot_loader #(
  parameter int          DEPTH       = 1024,
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] NOP_WORD    = 32'h00000013,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, HOLD, RUN} state_t;

  localparam int                HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

`ifdef BOOT_CLEAR_EN
  localparam state_t BOOT_ST = CLEAR;
`else
  localparam state_t BOOT_ST = LOAD;
  logic unused_nop;
  assign unused_nop = ^NOP_WORD;
`endif

  state_t         state, nxt;
  logic [HCW-1:0] hold_cnt;
  logic           accept;

  // prog_ready is a state-decoded register, so accept never loops back into it.
  assign accept = prog_valid && prog_ready;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN: if (start) nxt = BOOT_ST;
`ifdef BOOT_CLEAR_EN
      CLEAR:     if (imem_addr == LAST_ADDR) nxt = LOAD;
`endif
      LOAD:      if (accept && (prog_last || load_count == LAST_CNT)) nxt = HOLD;
      HOLD:      if (hold_cnt == HCW'(HOLD_CYCLES - 1)) nxt = RUN;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      prog_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      load_count <= '0;
    end else begin
      state      <= nxt;
      // Status outputs are decoded from the next state so they line up with it.
      prog_ready <= (nxt == LOAD);
      cpu_reset  <= (nxt != RUN);
      busy       <= (nxt == CLEAR) || (nxt == LOAD) || (nxt == HOLD);
      done       <= (nxt == RUN);
      imem_we    <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            load_count <= '0;
            overflow   <= 1'b0;
            hold_cnt   <= '0;
`ifdef BOOT_CLEAR_EN
            imem_we    <= 1'b1;
            imem_addr  <= '0;
            imem_wdata <= NOP_WORD;
`endif
          end
        end
`ifdef BOOT_CLEAR_EN
        CLEAR: begin
          if (imem_addr != LAST_ADDR) begin
            imem_we   <= 1'b1;
            imem_addr <= imem_addr + ADDR_W'(1);
          end
        end
`endif
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= load_count[ADDR_W-1:0];
            imem_wdata <= prog_data;
            load_count <= load_count + (ADDR_W+1)'(1);
            if (!prog_last && load_count == LAST_CNT) overflow <= 1'b1;
          end
        end
        HOLD:    hold_cnt <= hold_cnt + HCW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: every expected imem write is queued when
// stimulus is driven and checked when imem_we appears; a shadow imem tracks contents.
module tb_imem_boot_loader;
  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 10;
  localparam int          HOLD   = 2;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset, start, prog_valid, prog_last;
  logic [31:0]       prog_data;
  logic              prog_ready, imem_we, cpu_reset, busy, done, overflow;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   load_count;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .overflow(overflow), .load_count(load_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [ADDR_W-1:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q[$];
  logic [31:0] mem [DEPTH];
  int          tests = 0, fails = 0, wr_cnt = 0, lc = 0;

  // Write monitor: every imem write must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      mem[imem_addr] = imem_wdata;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, want no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr %h data %h, want addr %h data %h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; prog_valid = 0; prog_last = 0; prog_data = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    exp_q.delete();
    lc = 0;
  endtask

  // Pulse start and wait for LOAD; in the clear build the DEPTH NOP writes are queued.
  task automatic boot(input string name);
    @(negedge clk);
    start = 1;
`ifdef BOOT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: ADDR_W'(i), data: NOP});
`endif
    lc = 0;
    @(negedge clk);
    start = 0;
    tests++;
    if ({busy, cpu_reset, done} !== 3'b110) begin
      fails++;
      $display("FAIL %s_boot_status: got busy/cpu_reset/done %b, want 110", name, {busy, cpu_reset, done});
    end
`ifdef BOOT_CLEAR_EN
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== '0) begin
      fails++;
      $display("FAIL %s_first_clear: got we %b addr %h, want we 1 addr 0", name, imem_we, imem_addr);
    end
`else
    tests++;
    if (prog_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready_e1: got %b, want 1", name, prog_ready);
    end
`endif
    for (int i = 0; i < DEPTH + 8 && prog_ready !== 1'b1; i++) @(negedge clk);
    tests++;
    if (prog_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready_timeout: got prog_ready %b, want 1", name, prog_ready);
    end
`ifdef BOOT_CLEAR_EN
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_clear_count: got %0d clear writes outstanding, want 0", name, exp_q.size());
    end
`endif
  endtask

  // Offer one beat; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 0;
    prog_valid = 1; prog_data = d; prog_last = last;
    for (int i = 0; i < 64; i++) begin
      if (prog_ready === 1'b1) begin
        exp_q.push_back('{addr: ADDR_W'(lc), data: d});
        lc++;
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    prog_valid = 0; prog_last = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL beat_timeout: got no accept for %h, want accept", d);
    end
  endtask

  // Called in cycle L+1 after the terminating beat.
  task automatic check_hold(input string name);
    tests++;
    if ({cpu_reset, prog_ready, busy} !== 3'b101) begin
      fails++;
      $display("FAIL %s_hold_enter: got cpu_reset/ready/busy %b, want 101", name, {cpu_reset, prog_ready, busy});
    end
    repeat (HOLD - 1) @(negedge clk);
    tests++;
    if ({cpu_reset, done} !== 2'b10) begin
      fails++;
      $display("FAIL %s_hold_last: got cpu_reset/done %b, want 10", name, {cpu_reset, done});
    end
    @(negedge clk);
    tests++;
    if ({cpu_reset, done, busy} !== 3'b010) begin
      fails++;
      $display("FAIL %s_release: got cpu_reset/done/busy %b, want 010", name, {cpu_reset, done, busy});
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL reset_cpu_reset: got %b, want 1", cpu_reset);
    end
    tests++;
    if ({prog_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow, load_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ready %b we %b addr %h wdata %h busy %b done %b ovf %b cnt %0d, want all 0",
               prog_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow, load_count);
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    boot("basic");
    send(32'h00a00093, 0);
    send(32'h00500113, 0);
    send(32'h002081b3, 1);
    check_hold("basic");
    tests++;
    if (load_count !== 11'd3) begin
      fails++;
      $display("FAIL basic_load_count: got %0d, want 3", load_count);
    end
    tests++;
    if (mem[0] !== 32'h00a00093 || mem[1] !== 32'h00500113 || mem[2] !== 32'h002081b3) begin
      fails++;
      $display("FAIL basic_program: got %h %h %h, want 00a00093 00500113 002081b3", mem[0], mem[1], mem[2]);
    end
`ifdef BOOT_CLEAR_EN
    for (int i = 3; i < DEPTH; i++) if (mem[i] !== NOP) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL basic_nop_fill: got %0d non-NOP words above 2, want 0", bad);
    end
`endif
  endtask

  task automatic test_gap();
    boot("gap");
    send(32'h11111111, 0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      tests++;
      if (imem_we !== 1'b0) begin
        fails++;
        $display("FAIL gap_write: got imem_we %b in gap %0d, want 0", imem_we, g);
      end
    end
    send(32'h22222222, 0);
    send(32'h33333333, 1);
    check_hold("gap");
    tests++;
    if (load_count !== 11'd3 || mem[1] !== 32'h22222222 || mem[2] !== 32'h33333333) begin
      fails++;
      $display("FAIL gap_result: got cnt %0d mem1 %h mem2 %h, want 3 22222222 33333333",
               load_count, mem[1], mem[2]);
    end
  endtask

  task automatic test_start_in_load();
    boot("sil");
    send(32'haaaa0001, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    tests++;
    if ({prog_ready, busy, imem_we} !== 3'b110 || load_count !== 11'd1) begin
      fails++;
      $display("FAIL sil_ignored: got ready/busy/we %b cnt %0d, want 110 cnt 1",
               {prog_ready, busy, imem_we}, load_count);
    end
    send(32'haaaa0002, 1);
    check_hold("sil");
    tests++;
    if (load_count !== 11'd2 || mem[1] !== 32'haaaa0002) begin
      fails++;
      $display("FAIL sil_result: got cnt %0d mem1 %h, want 2 aaaa0002", load_count, mem[1]);
    end
  endtask

  task automatic test_overflow();
    int w0;
    boot("ovf");
    w0 = wr_cnt;
    for (int i = 0; i < DEPTH; i++) send(32'hc0000000 | i, 0);
    prog_valid = 1; prog_data = 32'hdeadbeef; prog_last = 0;
    check_hold("ovf");
    prog_valid = 0;
    #1;
    tests++;
    if (overflow !== 1'b1 || load_count !== 11'd1024) begin
      fails++;
      $display("FAIL ovf_flags: got overflow %b cnt %0d, want 1 1024", overflow, load_count);
    end
    tests++;
    if (wr_cnt - w0 != DEPTH) begin
      fails++;
      $display("FAIL ovf_writes: got %0d load writes, want %0d", wr_cnt - w0, DEPTH);
    end
  endtask

  task automatic test_reboot();
    boot("reboot");
    tests++;
    if (overflow !== 1'b0 || load_count !== '0) begin
      fails++;
      $display("FAIL reboot_cleared: got overflow %b cnt %0d, want 0 0", overflow, load_count);
    end
    send(32'h00000093, 1);
    check_hold("reboot");
    tests++;
    if (mem[0] !== 32'h00000093 || load_count !== 11'd1) begin
      fails++;
      $display("FAIL reboot_program: got mem0 %h cnt %0d, want 00000093 1", mem[0], load_count);
    end
  endtask

  task automatic test_reset_abort();
`ifdef BOOT_CLEAR_EN
    int w0;
    bit hit = 0;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: ADDR_W'(i), data: NOP});
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 600; i++) begin
      if (imem_we === 1'b1 && imem_addr === ADDR_W'(500)) begin hit = 1; break; end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL abort_reach500: got addr %h, want 1f4", imem_addr);
    end
`else
    boot("abort");
    send(32'h0bad0001, 0);
    send(32'h0bad0002, 0);
`endif
    reset = 1;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    tests++;
    if ({imem_we, cpu_reset, busy, done, prog_ready} !== 5'b01000 || load_count !== '0) begin
      fails++;
      $display("FAIL abort_idle: got we/cpu_reset/busy/done/ready %b cnt %0d, want 01000 0",
               {imem_we, cpu_reset, busy, done, prog_ready}, load_count);
    end
    repeat (5) @(negedge clk);
`ifdef BOOT_CLEAR_EN
    #1;
    tests++;
    if (wr_cnt - w0 != 501) begin
      fails++;
      $display("FAIL abort_writes: got %0d writes, want 501", wr_cnt - w0);
    end
`endif
  endtask

  initial begin
    reset = 1; start = 0; prog_valid = 0; prog_last = 0; prog_data = '0;
    test_reset();
    test_basic();
    test_gap();
    test_start_in_load();
    test_overflow();
    test_reboot();
    test_reset_abort();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
